// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter
//
// Two-port arbiter and access sequencer for a byte-addressed, word-wide data
// memory.  Port 0 serves the pipeline MEM stage, port 1 the loader/debug
// requester.  The memory only writes whole words, so byte and halfword stores
// are performed as a read (ACCESS) followed by a merged write (MERGE).
// Misaligned or out-of-range requests are rejected without touching memory.
//
// Handshake (both ports): a requester raises pN_req with we/size/addr/wdata
// and holds them stable until pN_ack.  pN_ack is a one-cycle pulse; pN_err
// and pN_rdata are valid in that same cycle, and pN_rdata holds its value
// until the next pN_ack of that port.  A req still high in the cycle after
// ack is a new request.  Fields are latched at grant, so later changes are
// ignored.
//
// Ports:
//   clk, rst_n         clock; synchronous active-low reset
//   pN_req/we/size     request, write(1)/read(0), size 00 byte 01 half 10 word
//   pN_addr, pN_wdata  byte address, store data (low bits for byte/half)
//   pN_ack, pN_err     completion pulse, error flag valid with ack
//   pN_rdata           registered load data (0 after a write or an error)
//   mem_ce, mem_we     memory chip enable / write enable
//   mem_addr           word-aligned memory byte address
//   mem_wdata          memory write word
//   mem_rdata          memory read word, combinational from mem_addr
//   dbg_state_o        current sequencer state (IDLE=0 ACCESS=1 MERGE=2 DONE=3)
// ============================================================================
module dmem_arbiter #(
   parameter int unsigned MEM_BYTES = 1024,
   parameter int unsigned ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   // port 0
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [1:0]        p0_size,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [31:0]       p0_wdata,
   output logic              p0_ack,
   output logic              p0_err,
   output logic [31:0]       p0_rdata,
   // port 1
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [1:0]        p1_size,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [31:0]       p1_wdata,
   output logic              p1_ack,
   output logic              p1_err,
   output logic [31:0]       p1_rdata,
   // memory
   output logic              mem_ce,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   // debug
   output logic [1:0]        dbg_state_o
);

   localparam int unsigned AW1 = ADDR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_MERGE  = 2'd2,
      S_DONE   = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic                rr_last_q, rr_last_d;
   logic                port_q, port_d;
   logic                we_q, we_d;
   logic [1:0]          size_q, size_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                err_q, err_d;
   logic [31:0]         old_word_q, old_word_d;
   logic [31:0]         p0_rdata_q, p0_rdata_d;
   logic [31:0]         p1_rdata_q, p1_rdata_d;

   // Selected request in IDLE
   logic                grant_p1;
   logic                sel_we;
   logic [1:0]          sel_size;
   logic [ADDR_W-1:0]   sel_addr;
   logic [31:0]         sel_wdata;
   logic                sel_illegal;

   // Datapath helpers
   logic [4:0]          lane_shift;
   logic [31:0]         rd_shifted;
   logic [31:0]         rd_extract;
   logic [31:0]         lane_mask;
   logic [31:0]         merged_word;
   logic                mem_we_raw;

   // -------------------------------------------------------------------------
   // Legality: bad size, misalignment, or any byte beyond the memory end.
   // The end address is formed one bit wider so it cannot wrap.
   // -------------------------------------------------------------------------
   function automatic logic is_illegal(input logic [1:0] size,
                                       input logic [ADDR_W-1:0] addr);
      logic [AW1-1:0] end_addr;
      logic [AW1-1:0] nbytes;
      logic           bad;
      case (size)
         2'b00:   nbytes = AW1'(1);
         2'b01:   nbytes = AW1'(2);
         default: nbytes = AW1'(4);
      endcase
      end_addr = {1'b0, addr} + nbytes;
      bad = 1'b0;
      if (size == 2'b11)                       bad = 1'b1;
      if (size == 2'b01 && addr[0])            bad = 1'b1;
      if (size == 2'b10 && addr[1:0] != 2'b00) bad = 1'b1;
      if (end_addr > AW1'(MEM_BYTES))          bad = 1'b1;
      return bad;
   endfunction

   // -------------------------------------------------------------------------
   // Arbitration: a lone requester wins; on contention the port that did not
   // win last time wins.
   // -------------------------------------------------------------------------
   always_comb begin
      grant_p1    = p1_req && (!p0_req || !rr_last_q);
      sel_we      = grant_p1 ? p1_we    : p0_we;
      sel_size    = grant_p1 ? p1_size  : p0_size;
      sel_addr    = grant_p1 ? p1_addr  : p0_addr;
      sel_wdata   = grant_p1 ? p1_wdata : p0_wdata;
      sel_illegal = is_illegal(sel_size, sel_addr);
   end

   // -------------------------------------------------------------------------
   // Byte-lane datapath, driven from the latched request.
   // -------------------------------------------------------------------------
   always_comb begin
      lane_shift = {addr_q[1:0], 3'b000};
      rd_shifted = mem_rdata >> lane_shift;
      case (size_q)
         2'b00:   rd_extract = {24'h0, rd_shifted[7:0]};
         2'b01:   rd_extract = {16'h0, rd_shifted[15:0]};
         default: rd_extract = rd_shifted;
      endcase
      lane_mask   = (size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
      merged_word = (old_word_q & ~(lane_mask << lane_shift))
                  | ((wdata_q & lane_mask) << lane_shift);
   end

   // -------------------------------------------------------------------------
   // Next-state and memory outputs.  Load data is written into the winning
   // port's rdata register on the edge that enters DONE, so it is already
   // valid while ack is high.
   // -------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      rr_last_d  = rr_last_q;
      port_d     = port_q;
      we_d       = we_q;
      size_d     = size_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      err_d      = err_q;
      old_word_d = old_word_q;
      p0_rdata_d = p0_rdata_q;
      p1_rdata_d = p1_rdata_q;
      mem_ce     = 1'b0;
      mem_we_raw = 1'b0;
      mem_addr   = '0;
      mem_wdata  = 32'h0;

      case (state_q)
         S_IDLE: begin
            if (p0_req || p1_req) begin
               rr_last_d = grant_p1;
               port_d    = grant_p1;
               we_d      = sel_we;
               size_d    = sel_size;
               addr_d    = sel_addr;
               wdata_d   = sel_wdata;
               if (sel_illegal) begin
                  err_d = 1'b1;
                  if (grant_p1) p1_rdata_d = 32'h0;
                  else          p0_rdata_d = 32'h0;
                  state_d = S_DONE;
               end else begin
                  err_d   = 1'b0;
                  state_d = S_ACCESS;
               end
            end
         end

         S_ACCESS: begin
            mem_ce   = 1'b1;
            mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
            if (!we_q) begin
               if (port_q) p1_rdata_d = rd_extract;
               else        p0_rdata_d = rd_extract;
               state_d = S_DONE;
            end else if (size_q == 2'b10) begin
               mem_we_raw = 1'b1;
               mem_wdata  = wdata_q;
               if (port_q) p1_rdata_d = 32'h0;
               else        p0_rdata_d = 32'h0;
               state_d = S_DONE;
            end else begin
               // Sub-word store: fetch the surrounding word first.
               old_word_d = mem_rdata;
               state_d    = S_MERGE;
            end
         end

         S_MERGE: begin
            mem_ce     = 1'b1;
            mem_we_raw = 1'b1;
            mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
            mem_wdata  = merged_word;
            if (port_q) p1_rdata_d = 32'h0;
            else        p0_rdata_d = 32'h0;
            state_d = S_DONE;
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Gating with rst_n guarantees that a reset edge landing on a write cycle
   // leaves the memory untouched.
   assign mem_we = mem_we_raw & rst_n;

   // -------------------------------------------------------------------------
   // Port outputs
   // -------------------------------------------------------------------------
   assign p0_ack      = (state_q == S_DONE) && !port_q;
   assign p1_ack      = (state_q == S_DONE) &&  port_q;
   assign p0_err      = p0_ack && err_q;
   assign p1_err      = p1_ack && err_q;
   assign p0_rdata    = p0_rdata_q;
   assign p1_rdata    = p1_rdata_q;
   assign dbg_state_o = state_q;

   // -------------------------------------------------------------------------
   // State registers.  rr_last resets to 1 so port 0 wins the first contest.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         rr_last_q  <= 1'b1;
         port_q     <= 1'b0;
         we_q       <= 1'b0;
         size_q     <= 2'b00;
         addr_q     <= '0;
         wdata_q    <= 32'h0;
         err_q      <= 1'b0;
         old_word_q <= 32'h0;
         p0_rdata_q <= 32'h0;
         p1_rdata_q <= 32'h0;
      end else begin
         state_q    <= state_d;
         rr_last_q  <= rr_last_d;
         port_q     <= port_d;
         we_q       <= we_d;
         size_q     <= size_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         err_q      <= err_d;
         old_word_q <= old_word_d;
         p0_rdata_q <= p0_rdata_d;
         p1_rdata_q <= p1_rdata_d;
      end
   end

endmodule
